imem_boot_loader: RTL

- Writer side of the processor's instruction memory; TOP_Processor is the reader.
- Accepts a byte stream (length header, then little-endian 32-bit instruction words) over a valid/ready handshake.
- Writes each assembled word into instruction memory at consecutive word addresses.
- Holds the processor in reset through CPU_RST until the image is fully loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// imem_boot_loader : loads a length-prefixed byte stream into instruction
// memory and holds the CPU in reset until the image is complete.
// Optional checksum trailer byte: define IMEM_BOOT_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              CPU_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE_S = 3'd4,
    ERR_S  = 3'd5
`ifdef IMEM_BOOT_CHECKSUM_EN
    , CSUM = 3'd6
`endif
  } state_t;

  localparam int unsigned c_capacity = 32'd1 << ADDR_W;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_t c_last_state = CSUM;
`else
  localparam state_t c_last_state = DONE_S;
`endif

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                w_in_load;
  logic                w_fire;
  logic                w_busy;
  logic                w_done;
  logic [15:0]         w_len_full;

  always_comb begin
    w_in_load = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
`ifdef IMEM_BOOT_CHECKSUM_EN
    w_in_load = w_in_load || (state_q == CSUM);
`endif
  end

  // The final write pulse still counts as busy; DONE appears the cycle after.
  assign w_busy     = w_in_load || ((state_q == DONE_S) && we_q);
  assign w_done     = (state_q == DONE_S) && !we_q;
  assign w_fire     = IN_VALID && w_in_load;
  assign w_len_full = {IN_DATA, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d     = csum_q;
    if (w_fire) begin
      csum_d = csum_q ^ IN_DATA;
    end
`endif
    case (state_q)
      IDLE, DONE_S, ERR_S: begin
        if (START && !w_busy) begin
          state_d    = LEN_LO;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          len_d      = 16'd0;
          addr_d     = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      LEN_LO: begin
        if (w_fire) begin
          len_d[7:0] = IN_DATA;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_fire) begin
          len_d = w_len_full;
          if (32'(w_len_full) > c_capacity) begin
            state_d = ERR_S;
          end else if (w_len_full == 16'd0) begin
            state_d = c_last_state;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (w_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = IN_DATA;
            2'd1: asm_d[15:8]  = IN_DATA;
            2'd2: asm_d[23:16] = IN_DATA;
            default: begin
              // Separate write register frees asm_q for the next word at once.
              we_d       = 1'b1;
              wdata_d    = {IN_DATA, asm_q};
              addr_d     = word_cnt_q[ADDR_W-1:0];
              word_cnt_d = word_cnt_q + 16'd1;
              if ((word_cnt_q + 16'd1) == len_q) begin
                state_d = c_last_state;
              end
            end
          endcase
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM: begin
        if (w_fire) begin
          state_d = (IN_DATA == csum_q) ? DONE_S : ERR_S;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign IN_READY  = w_in_load;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = w_busy;
  assign DONE      = w_done;
  assign CPU_RST   = !w_done;
  assign ERR       = (state_q == ERR_S);

endmodule
`default_nettype wire
